// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard control bus.
// Groups the stage stall requests and exception inputs with the hold, bubble,
// flush and redirect outputs.
//   slave  : the hazard controller (consumes requests, drives controls)
//   master : the pipeline side (drives requests, consumes controls)
`timescale 1ns/1ps
interface pipe_hazard_ctrl_if #(
  parameter int unsigned STAGES = 5
);
  logic [STAGES-1:0] stall_req_i;
  logic [31:0]       exc_type_i;
  logic [31:0]       cp0_epc_i;
  logic [STAGES-1:0] stall_o;
  logic [STAGES-1:0] bubble_o;
  logic              flush_o;
  logic [31:0]       new_pc_o;
  logic              stall_timeout_o;

  modport master (
    output stall_req_i, exc_type_i, cp0_epc_i,
    input  stall_o, bubble_o, flush_o, new_pc_o, stall_timeout_o
  );

  modport slave (
    input  stall_req_i, exc_type_i, cp0_epc_i,
    output stall_o, bubble_o, flush_o, new_pc_o, stall_timeout_o
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// N-stage pipeline stall/flush controller.
// Stall requests propagate combinationally to every older stage, and a bubble
// is inserted behind the youngest stalled stage. An exception redirect starts a
// registered FLUSH of FLUSH_CYC cycles that drives new_pc_o.
// Optional stall watchdog: define PIPE_HAZARD_WDOG_EN to build it. Otherwise
// stall_timeout_o is tied to 0.
// Ports:
//   clk_i  : clock
//   rst_i  : asynchronous active-high reset
//   bus    : pipe_hazard_ctrl_if.slave (stall_req_i, exc_type_i, cp0_epc_i in;
//            stall_o, bubble_o, flush_o, new_pc_o, stall_timeout_o out)
`timescale 1ns/1ps
module pipe_hazard_ctrl #(
  parameter int unsigned STAGES    = 5,
  parameter logic [31:0] INT_VEC   = 32'h0000_0020,
  parameter logic [31:0] EXC_VEC   = 32'h0000_0040,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned WDOG_W    = 8
) (
  input logic              clk_i,
  input logic              rst_i,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;
  localparam logic [3:0] FC_LAST = 4'(FLUSH_CYC - 1);

  logic [0:0]  state_q, state_n;
  logic [3:0]  fc_q, fc_n;
  logic        flush_q, flush_n;
  logic [31:0] pc_q, pc_n;
  logic        exc_hit;
  logic [31:0] target;
  logic [STAGES-1:0] stall_raw, bubble_raw;

  // Exception decode
  assign exc_hit = (bus.exc_type_i != 32'h0);

  always_comb begin
    if (bus.exc_type_i == 32'h1)      target = INT_VEC;
    else if (bus.exc_type_i == 32'hE) target = bus.cp0_epc_i;
    else                              target = EXC_VEC;
  end

  // Next-state logic. The final FLUSH cycle counts as the boundary into RUN,
  // so an exception present there restarts the flush with no idle cycle.
  always_comb begin
    state_n = state_q;
    fc_n    = fc_q;
    flush_n = flush_q;
    pc_n    = pc_q;
    case (state_q)
      RUN: begin
        if (exc_hit) begin
          state_n = FLUSH;
          flush_n = 1'b1;
          fc_n    = 4'd0;
          pc_n    = target;
        end
      end
      FLUSH: begin
        fc_n = fc_q + 4'd1;
        if (fc_q == FC_LAST) begin
          if (exc_hit) begin
            fc_n = 4'd0;
            pc_n = target;
          end else begin
            state_n = RUN;
            flush_n = 1'b0;
            fc_n    = 4'd0;
          end
        end
      end
      default: begin
        state_n = RUN;
        flush_n = 1'b0;
        fc_n    = 4'd0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
      fc_q    <= 4'd0;
      flush_q <= 1'b0;
      pc_q    <= 32'h0;
    end else begin
      state_q <= state_n;
      fc_q    <= fc_n;
      flush_q <= flush_n;
      pc_q    <= pc_n;
    end
  end

  // Stage k holds when it or any younger stage stalls
  for (genvar k = 0; k < STAGES; k++) begin : g_stall
    assign stall_raw[k] = |bus.stall_req_i[STAGES-1:k];
  end

  // Bubble goes behind the youngest stalled stage
  for (genvar k = 0; k < STAGES - 1; k++) begin : g_bubble
    assign bubble_raw[k] = stall_raw[k] & ~stall_raw[k+1];
  end
  assign bubble_raw[STAGES-1] = 1'b0;

  assign bus.stall_o  = (rst_i || state_q != RUN) ? '0 : stall_raw;
  assign bus.bubble_o = (rst_i || state_q != RUN) ? '0 : bubble_raw;
  assign bus.flush_o  = flush_q;
  assign bus.new_pc_o = pc_q;

`ifdef PIPE_HAZARD_WDOG_EN
  logic [WDOG_W-1:0] wd_q, wd_n;
  logic              to_q;

  // Saturating count of consecutive stalled RUN cycles
  always_comb begin
    wd_n = '0;
    if (state_q == RUN && |bus.stall_req_i)
      wd_n = (&wd_q) ? wd_q : wd_q + WDOG_W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wd_q <= '0;
      to_q <= 1'b0;
    end else begin
      wd_q <= wd_n;
      to_q <= to_q | (&wd_n);
    end
  end

  assign bus.stall_timeout_o = to_q;
`else
  assign bus.stall_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  req;
  logic [31:0] exc, epc;
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.STAGES(5)) if1 ();
  pipe_hazard_ctrl_if #(.STAGES(5)) if3 ();

  assign if1.stall_req_i = req;
  assign if1.exc_type_i  = exc;
  assign if1.cp0_epc_i   = epc;
  assign if3.stall_req_i = req;
  assign if3.exc_type_i  = exc;
  assign if3.cp0_epc_i   = epc;

  pipe_hazard_ctrl #(.STAGES(5), .FLUSH_CYC(1), .WDOG_W(4)) u1 (
    .clk_i(clk), .rst_i(rst), .bus(if1));
  pipe_hazard_ctrl #(.STAGES(5), .FLUSH_CYC(3), .WDOG_W(4)) u3 (
    .clk_i(clk), .rst_i(rst), .bus(if3));

`ifdef PIPE_HAZARD_WDOG_EN
  localparam logic WD_ON = 1'b1;
`else
  localparam logic WD_ON = 1'b0;
`endif

  // Model: remaining flush cycles, redirect PC, stalled-cycle count, flag
  int          left [2];
  logic [31:0] mpc  [2];
  int          wdc  [2];
  logic        wto  [2];
  int          fcs  [2];
  initial begin fcs[0] = 1; fcs[1] = 3; end

  function automatic logic [31:0] tgt(input logic [31:0] e, input logic [31:0] p);
    if (e == 32'h1) return 32'h20;
    if (e == 32'hE) return p;
    return 32'h40;
  endfunction

  function automatic int top_req(input logic [4:0] r);
    int t = -1;
    for (int j = 0; j < 5; j++) if (r[j]) t = j;
    return t;
  endfunction

  // All stages up to the youngest requester hold
  function automatic logic [4:0] exp_stall(input logic [4:0] r);
    int t = top_req(r);
    if (t < 0) return 5'b0;
    return 5'((32'd1 << (t + 1)) - 1);
  endfunction

  // Single bubble at the youngest requester, none past WB
  function automatic logic [4:0] exp_bubble(input logic [4:0] r);
    int t = top_req(r);
    if (t < 0 || t == 4) return 5'b0;
    return 5'(32'd1 << t);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        left[i] <= 0; mpc[i] <= 32'h0; wdc[i] <= 0; wto[i] <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        int nw;
        nw = (left[i] == 0 && req != 5'b0) ? ((wdc[i] < 15) ? wdc[i] + 1 : 15) : 0;
        wdc[i] <= nw;
        if (nw == 15) wto[i] <= 1'b1;
        if (left[i] <= 1 && exc != 32'h0) begin
          left[i] <= fcs[i];
          mpc[i]  <= tgt(exc, epc);
        end else if (left[i] > 0) begin
          left[i] <= left[i] - 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input int i, input logic [4:0] st, input logic [4:0] bu,
                     input logic fl, input logic [31:0] pc, input logic to);
    logic act;
    act = (left[i] > 0);
    chk($sformatf("m%0d.stall", i), 32'(st), act ? 32'h0 : 32'(exp_stall(req)));
    chk($sformatf("m%0d.bubble", i), 32'(bu), act ? 32'h0 : 32'(exp_bubble(req)));
    chk($sformatf("m%0d.flush", i), 32'(fl), 32'(act));
    if (act) chk($sformatf("m%0d.pc", i), pc, mpc[i]);
    chk($sformatf("m%0d.timeout", i), 32'(to), 32'(wto[i] & WD_ON));
  endtask

  // Every-cycle comparison against the model, mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      cmp(0, if1.stall_o, if1.bubble_o, if1.flush_o, if1.new_pc_o, if1.stall_timeout_o);
      cmp(1, if3.stall_o, if3.bubble_o, if3.flush_o, if3.new_pc_o, if3.stall_timeout_o);
    end
  end

  task automatic drive(input logic [4:0] r, input logic [31:0] e, input logic [31:0] p);
    @(posedge clk);
    #2;
    req = r; exc = e; epc = p;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(5'b0, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; req = 5'b11111; exc = 32'h0; epc = 32'h0;
    @(posedge clk); #2;
    chk("rst.flush", 32'(if1.flush_o), 32'h0);
    chk("rst.pc", if1.new_pc_o, 32'h0);
    chk("rst.stall", 32'(if1.stall_o), 32'h0);
    chk("rst.bubble", 32'(if1.bubble_o), 32'h0);
    chk("rst.timeout", 32'(if1.stall_timeout_o), 32'h0);
    req = 5'b0;
    @(negedge clk); #1 rst = 1'b0;

    // Stall propagation and same-cycle release
    drive(5'b00100, 32'h0, 32'h0);
    @(negedge clk);
    chk("prop.stall", 32'(if1.stall_o), 32'h07);
    chk("prop.bubble", 32'(if1.bubble_o), 32'h04);
    #1 req = 5'b0;
    #1 chk("prop.release", 32'(if1.stall_o), 32'h0);
    drive(5'b10000, 32'h0, 32'h0);
    @(negedge clk);
    chk("wb.stall", 32'(if1.stall_o), 32'h1F);
    chk("wb.bubble", 32'(if1.bubble_o), 32'h0);

    // Interrupt, stall forced off during flush
    drive(5'b0, 32'h1, 32'h0);
    @(negedge clk); chk("int.pre", 32'(if1.flush_o), 32'h0);
    drive(5'b11111, 32'h0, 32'h0);
    @(negedge clk);
    chk("int.flush", 32'(if1.flush_o), 32'h1);
    chk("int.pc", if1.new_pc_o, 32'h20);
    chk("int.stall", 32'(if1.stall_o), 32'h0);
    drive(5'b0, 32'h0, 32'h0);
    @(negedge clk); chk("int.done", 32'(if1.flush_o), 32'h0);
    idle(3);

    // ERET on the 3-cycle flush, nested exception ignored
    drive(5'b0, 32'hE, 32'hBFC0_0100);
    drive(5'b0, 32'h0, 32'h0);
    @(negedge clk); chk("eret.c1", 32'(if3.flush_o), 32'h1);
    chk("eret.pc1", if3.new_pc_o, 32'hBFC0_0100);
    drive(5'b0, 32'h8, 32'h0);
    @(negedge clk); chk("eret.c2", 32'(if3.flush_o), 32'h1);
    drive(5'b0, 32'h0, 32'h0);
    @(negedge clk); chk("eret.c3", 32'(if3.flush_o), 32'h1);
    chk("eret.pc3", if3.new_pc_o, 32'hBFC0_0100);
    drive(5'b0, 32'h0, 32'h0);
    @(negedge clk); chk("eret.end", 32'(if3.flush_o), 32'h0);
    idle(2);

    // Back-to-back exceptions
    drive(5'b0, 32'hA, 32'h0);
    repeat (6) begin
      drive(5'b0, 32'hA, 32'h0);
      @(negedge clk);
      chk("b2b.flush", 32'(if1.flush_o), 32'h1);
      chk("b2b.pc", if1.new_pc_o, 32'h40);
    end
    idle(5);

    // Reset during the second flush cycle
    drive(5'b0, 32'h1, 32'h0);
    drive(5'b0, 32'h0, 32'h0);
    drive(5'b0, 32'h0, 32'h0);
    #1 chk("mid.pre", 32'(if3.flush_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid.flush", 32'(if3.flush_o), 32'h0);
    chk("mid.pc", if3.new_pc_o, 32'h0);
    chk("mid.timeout", 32'(if3.stall_timeout_o), 32'h0);
    @(negedge clk); #1 rst = 1'b0;
    drive(5'b00010, 32'h0, 32'h0);
    @(negedge clk);
    chk("mid.run", 32'(if3.stall_o), 32'h03);
    chk("mid.noflush", 32'(if3.flush_o), 32'h0);

    // Watchdog
    repeat (14) drive(5'b00001, 32'h0, 32'h0);
    @(negedge clk); chk("wd.before", 32'(if1.stall_timeout_o), 32'h0);
    drive(5'b00001, 32'h0, 32'h0);
    drive(5'b0, 32'h0, 32'h0);
    @(negedge clk); chk("wd.set", 32'(if1.stall_timeout_o), 32'(WD_ON));
    idle(2);
    @(negedge clk); chk("wd.sticky", 32'(if1.stall_timeout_o), 32'(WD_ON));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline stall/flush controller for the CPU core. It generalises the single-source stall/flush logic to N stages, each with its own stall request, and generates the matching bubble-insert strobes. Exception redirects are registered: a FLUSH state machine holds flush for a configurable number of cycles. An optional stall watchdog is included. It sits beside the pipeline registers, taking busy requests from stages and the exception type from the MEM/CP0 stage, and drives the hold, bubble, flush and redirect PC outputs.

## Interface
- STAGES, 5: number of pipeline stages; stage 0 = IF, stage STAGES-1 = WB.
- INT_VEC, 32'h0000_0020: redirect PC for interrupt.
- EXC_VEC, 32'h0000_0040: redirect PC for all synchronous exceptions.
- FLUSH_CYC, 1: cycles flush_o stays high per redirect; legal range 1..15.
- WDOG_W, 8: watchdog counter width.

Ports:
- clk_i  in  1  clock; all state on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- stall_req_i  in  STAGES  bit k: stage k cannot complete this cycle.
- exc_type_i  in  32  exception type; 0 = none.
- cp0_epc_i  in  32  EPC for ERET.
- stall_o  out  STAGES  bit k: hold stage-k pipeline register.
- bubble_o  out  STAGES  bit k: load NOP into stage-k+1 register.
- flush_o  out  1  clear all pipeline registers.
- new_pc_o  out  32  redirect target, valid while flush_o=1.
- stall_timeout_o  out  1  sticky watchdog flag.

## Operation
- States: RUN and FLUSH. The 4-bit flush counter fc counts up in FLUSH.
- Stall propagation in RUN: stall_o[k] = OR of stall_req_i[j] for j >= k, so a stalled stage holds every older stage.
- Bubble generation in RUN:
  - bubble_o[k] = stall_o[k] & ~stall_o[k+1] for k < STAGES-1.
  - bubble_o[STAGES-1] = 0.
- Exception decode (priority over stall), from exc_type_i:
  - 32'h1: target INT_VEC.
  - 32'hE: ERET, target cp0_epc_i sampled in the detection cycle.
  - Any other nonzero value: target EXC_VEC.
- RUN -> FLUSH: when exc_type_i != 0 at the clock edge.
  - new_pc_o <= decoded target.
  - flush_o <= 1.
  - fc <= 0.
- FLUSH behaviour:
  - stall_o = 0 and bubble_o = 0, forced.
  - exc_type_i is ignored; no nesting and no target change.
  - fc increments each cycle.
  - When fc == FLUSH_CYC-1: flush_o <= 0 and return to RUN.
- In RUN, new_pc_o holds its last value. It is only meaningful while flush_o=1.
- Watchdog, counter wd of WDOG_W bits:
  - In RUN with |stall_req_i: wd increments, saturating at all-ones.
  - Otherwise: wd clears to 0.
  - stall_timeout_o sets when wd reaches all-ones and stays set until reset.
  - Counting does not affect stalling.

## Timing
- Stall and bubble paths are combinational from stall_req_i, with zero latency.
- While rst_i=1, stall_o and bubble_o are forced to 0.
- Exception-to-flush latency is 1 cycle. If exc_type_i is seen at edge n, flush_o is high from edge n for exactly FLUSH_CYC cycles. The first RUN cycle starts at edge n+FLUSH_CYC.
- Exception and stall in the same RUN cycle: the stall applies in that cycle, and the flush follows at the next edge.
- Back-to-back exceptions: the cycle at edge n+FLUSH_CYC is RUN, so an exception present there triggers a new FLUSH with 0 idle cycles.
- Reset values (asynchronous):
  - state = RUN, fc = 0, flush_o = 0, new_pc_o = 32'h0.
  - wd = 0, stall_timeout_o = 0.
- Reset mid-FLUSH aborts immediately: flush_o drops in the same cycle as rst_i.
- No CDC; single clock domain.

## Configuration
- PIPE_HAZARD_WDOG_EN
  - Defined: the watchdog counter and sticky flag are built as described.
  - Undefined: the counter is removed, stall_timeout_o is tied to 0, and WDOG_W is unused.

## Test plan
- Stall propagation: STAGES=5, stall_req_i=5'b00100 -> stall_o=5'b00111, bubble_o=5'b00100. Then 5'b00000 -> all zero in the same cycle.
- Interrupt: exc_type_i=32'h1 for one cycle -> next edge flush_o=1 and new_pc_o=32'h20 for 1 cycle. stall_o is forced 0 during the flush even with stall_req_i=5'b11111.
- ERET with FLUSH_CYC=3: exc_type_i=32'hE, cp0_epc_i=32'hBFC0_0100 -> flush_o high exactly 3 cycles with new_pc_o=32'hBFC0_0100. A second exception of type 32'h8 in flush cycle 2 is ignored.
- Back-to-back: type 32'hA held high continuously with FLUSH_CYC=1 -> flush_o stays high on every cycle and new_pc_o=32'h40.
- Reset mid-flush: assert rst_i during the 2nd FLUSH cycle -> flush_o, new_pc_o and stall_timeout_o go to 0 without waiting for a clock edge. After deassert, state is RUN.
- Watchdog (macro defined, WDOG_W=4): hold stall_req_i nonzero 15 cycles -> stall_timeout_o rises and stays 1 after the stall clears. With the macro undefined it stays 0.
